// File: rtl/pipe_pkg.sv
// Shared types for the inter-stage pipeline registers of the MIPS32 core.
package pipe_pkg;

    localparam int PS_DATA_W = 32;
    localparam int PS_ADDR_W = 5;

    // Write-back beat carried across EX->MEM and MEM->WB at the core's native widths.
    typedef struct packed {
        logic [PS_DATA_W-1:0] result;
        logic [PS_ADDR_W-1:0] write_addr;
        logic                 write_enable;
    } wb_beat_t;

    // Occupancy of a stage. PS_FULL is only reachable when a skid entry exists.
    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } ps_state_e;

endpackage

// File: rtl/pipe_stage_sat_counter.sv
// Saturating up-counter: sticks at all-ones, cleared only by reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Increment on request unless already at the ceiling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipe_stage.sv
// Elastic pipeline-stage register with optional skid entry, flush and a
// saturating stall counter for performance debug.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = PS_DATA_W,
    parameter int ADDR_W = PS_ADDR_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] result_i,
    input  logic [ADDR_W-1:0] writeAddr_i,
    input  logic              writeEnable_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result_o,
    output logic [ADDR_W-1:0] writeAddr_o,
    output logic              writeEnable_o,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Same field layout as wb_beat_t, sized by this instance's parameters.
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [ADDR_W-1:0] write_addr;
        logic              write_enable;
    } beat_t;

    ps_state_e state;
    beat_t     main_q;
    beat_t     skid_q;
    beat_t     in_beat;
    logic      in_fire;
    logic      out_fire;

    assign in_beat   = {result_i, writeAddr_i, writeEnable_i};
    assign out_valid = (state != PS_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // With a skid entry, in_ready comes straight from a flop; without it,
    // the stage passes downstream readiness through combinationally.
    if (SKID != 0) begin : g_skid_ready
        assign in_ready = (state != PS_FULL);
    end else begin : g_pass_ready
        assign in_ready = !out_valid | out_ready;
    end

    assign result_o      = main_q.result;
    assign writeAddr_o   = main_q.write_addr;
    assign writeEnable_o = main_q.write_enable;

    // Stage FSM and data entries; flush beats every handshake, and the write
    // enable is dropped whenever main stops holding a live beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= PS_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state               <= PS_EMPTY;
            main_q.write_enable <= 1'b0;
        end else begin
            case (state)
                PS_EMPTY: begin
                    if (in_fire) begin
                        main_q <= in_beat;
                        state  <= PS_ONE;
                    end
                end
                PS_ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_beat;
                    end else if (in_fire && (SKID != 0)) begin
                        skid_q <= in_beat;
                        state  <= PS_FULL;
                    end else if (out_fire) begin
                        main_q.write_enable <= 1'b0;
                        state               <= PS_EMPTY;
                    end
                end
                PS_FULL: begin
                    // Input is blocked here, so only the drain move applies.
                    if (out_fire) begin
                        main_q <= skid_q;
                        state  <= PS_ONE;
                    end
                end
                default: state <= PS_EMPTY;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid & !out_ready),
        .count (stall_cnt)
    );

endmodule
